sequence_gen: RTL and testbench
===============================

# sequence_gen

Serial pattern generator that emits a programmed bit sequence, one bit per clock, MSB first, with a configurable bit length and repeat count. It is the stimulus and transmit counterpart of the overlapping serial sequence detector: its `data` output connects directly to a detector's `data` input. A parallel load handshake accepts a pattern. Back-to-back loads produce gapless serial streams.

## Interface
Parameters:
- `WIDTH`, 8: maximum pattern length in bits; must be ≥ 2.
- `LEN_W`, 3: width of `load_len`; must satisfy 2^LEN_W ≥ WIDTH.
- `REP_W`, 4: width of `load_rep`.

Ports (one clock; reset is asynchronous and active-low):
- `clk` input, 1: clock; all state changes on the rising edge.
- `rst` input, 1: asynchronous active-low reset.
- `load_data` input, WIDTH: pattern, right-aligned; bit `load_len` is sent first.
- `load_len` input, LEN_W: pattern length minus 1. Legal range is 1..WIDTH-1.
- `load_rep` input, REP_W: extra repetitions; the pattern is sent `load_rep`+1 times.
- `load_valid` input, 1: load request.
- `load_ready` output, 1: the generator can accept a load this cycle.
- `data` output, 1: serial bit, registered.
- `data_valid` output, 1: `data` is part of a pattern, registered.
- `last` output, 1: final bit of the final repetition, registered.
- `busy` output, 1: FSM is not IDLE.
- `abort` input, 1: synchronous cancel of the current burst.

## Operation
- FSM states: IDLE, SHIFT, and GAP (GAP exists only when the macro is enabled).
- **Reset:** `rst` low forces the following immediately, regardless of clock:
  - State is IDLE.
  - `data`, `data_valid`, `last`, and `busy` are 0.
  - `load_ready` is 1.
  - Internal pattern, bit index, and repeat counter are cleared.
- **Accept:** a load is accepted when `load_valid` && `load_ready` is true at a rising edge.
  - Latch `load_data`, `load_len`, and `load_rep`.
  - Set the bit index to `load_len` and the repeat counter to `load_rep`.
  - Go to SHIFT.
- **SHIFT, each cycle:**
  - Drive `data` = pattern[index] and `data_valid` = 1.
  - If index > 0, decrement index.
  - If index = 0 and rep > 0: decrement rep and reload index with len. The next state is GAP if the macro is enabled, otherwise SHIFT.
  - If index = 0 and rep = 0, this is the final bit: `last` = 1. The next state is SHIFT with new values if a load is accepted this cycle, otherwise IDLE.
- **`load_ready`:** high in IDLE, and in SHIFT during the final-bit cycle only. This allows gapless chaining.
- **`abort`:** in SHIFT or GAP, `abort` = 1 forces the next state to IDLE with outputs cleared. `abort` has priority over a simultaneous load, so the load is not accepted and `load_ready` is 0 that cycle. In IDLE, `abort` is ignored.
- **Illegal `load_len`:** a value of 0 or ≥ WIDTH is clamped to WIDTH-1.
- **Width rules:**
  - The index counter is LEN_W bits and the repeat counter is REP_W bits.
  - Neither counter wraps, because decrements occur only from nonzero values.
  - With `load_rep` = 2^REP_W-1, the pattern is sent 2^REP_W times.

## Timing
- **Latency:** the first bit appears on `data` in the cycle after the accepting edge, and is registered from that edge.
- **Burst length:** a burst occupies exactly (len+1)×(rep+1) `data_valid` cycles, plus rep GAP cycles if the macro is enabled.
- **Back-to-back loads:** a load accepted on the final-bit cycle produces its first bit on the very next cycle, with no `data_valid` bubble.
- **`busy`:** goes high the cycle after accept and goes low the cycle after `last`, unless a chained load was accepted.
- **Reset mid-burst:** all outputs drop within the same cycle (asynchronous). The first accept is possible at the first rising edge after `rst` deasserts.

## Configuration
- **`SEQ_GEN_GAP_EN` defined:** between repetitions, insert exactly one GAP cycle with `data` = 0, `data_valid` = 0, and `last` = 0. After GAP, the next state is SHIFT from index len. `abort` during GAP goes to IDLE. No gap is inserted between separate chained loads.
- **`SEQ_GEN_GAP_EN` undefined:** the GAP state is not compiled and repetitions are contiguous.

## Test plan
- **Single pattern:** reset, then load `load_data`=4'b1011, `load_len`=3, `load_rep`=0.
  - `data` = 1,0,1,1 on cycles 1–4 after accept, with `data_valid` high on those cycles and `last` on cycle 4.
  - Feeding `data` into the 1011 detector gives one flag.
- **Overlap stimulus:** pattern 1011, rep=1, macro off.
  - Stream is 1,0,1,1,1,0,1,1 with no `data_valid` gap.
  - The detector flags twice.
  - With the macro on, an idle cycle with `data`=0 follows the 4th bit.
- **Back-to-back:** hold `load_valid` high. Load 3'b110 (len=2), then 2'b01 (len=1).
  - `load_ready` pulses on the final-bit cycle.
  - Stream is 1,1,0,0,1 with `data_valid` continuous for 5 cycles.
- **Abort with simultaneous load:** load 8'hA5 (len=7). On the 3rd bit, assert `abort` and `load_valid` together.
  - The load is not accepted.
  - `data_valid`, `busy`, and `last` read 0 on the next cycle.
  - The next load is accepted from IDLE.
- **Async reset mid-burst:** drive `rst` low between clock edges during SHIFT.
  - Outputs clear immediately and `load_ready` = 1.
  - After release, a new 1011 load produces correct output with latency 1.
- **Clamp and max repeat:**
  - `load_len`=0 (or, if WIDTH < 2^LEN_W, `load_len`=WIDTH) is treated as WIDTH-1: a full WIDTH bits are emitted.
  - `load_rep`=15 with `REP_W`=4 gives exactly 16 repetitions and a single `last` pulse.

Source files
------------

// File: rtl/sequence_gen.sv
// Serial pattern generator: shifts a loaded pattern out MSB first, one bit per clock, with repeats.
// Optional SEQ_GEN_GAP_EN inserts one idle GAP cycle between repetitions of the same pattern.
module sequence_gen #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 3,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LEN_W-1:0] load_len,
    input  logic [REP_W-1:0] load_rep,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             data,
    output logic             data_valid,
    output logic             last,
    output logic             busy,
    input  logic             abort
);

`ifdef SEQ_GEN_GAP_EN
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic             data_q, data_d;
    logic             dv_q, dv_d;
    logic             last_q, last_d;

    logic             final_bit;
    logic             accept;
    logic [LEN_W-1:0] clen;
    logic [LEN_W-1:0] idx_dec;

    // idx_q always names the pattern bit currently presented on data_q
    always_comb begin
        if (load_len == '0 || 32'(load_len) >= WIDTH) begin
            clen = LEN_W'(WIDTH - 1);
        end else begin
            clen = load_len;
        end
        idx_dec    = idx_q - 1'b1;
        final_bit  = (state_q == SHIFT) && (idx_q == '0) && (rep_q == '0);
        load_ready = (state_q == IDLE) || (final_bit && !abort);
        accept     = load_valid && load_ready;
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
        data_d  = 1'b0;
        dv_d    = 1'b0;
        last_d  = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (idx_q != '0) begin
                    idx_d  = idx_dec;
                    data_d = pat_q[idx_dec];
                    dv_d   = 1'b1;
                    last_d = (idx_q == LEN_W'(1)) && (rep_q == '0);
                end else if (rep_q != '0) begin
                    rep_d = rep_q - 1'b1;
                    idx_d = len_q;
`ifdef SEQ_GEN_GAP_EN
                    state_d = GAP;
`else
                    data_d = pat_q[len_q];
                    dv_d   = 1'b1;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
`ifdef SEQ_GEN_GAP_EN
            GAP: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    state_d = SHIFT;
                    data_d  = pat_q[idx_q];
                    dv_d    = 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        // Accept is only possible from IDLE or the final bit, so it overrides cleanly
        if (accept) begin
            state_d = SHIFT;
            pat_d   = load_data;
            len_d   = clen;
            idx_d   = clen;
            rep_d   = load_rep;
            data_d  = load_data[clen];
            dv_d    = 1'b1;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            rep_q   <= '0;
            data_q  <= 1'b0;
            dv_q    <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            last_q  <= last_d;
        end
    end

    assign data       = data_q;
    assign data_valid = dv_q;
    assign last       = last_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sequence_gen.sv
// Directed bench for sequence_gen: vector table of single loads plus chaining, abort, reset and max-repeat sequences.
module tb_sequence_gen;
    localparam int WIDTH = 8;
    localparam int LEN_W = 3;
    localparam int REP_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] load_data = '0;
    logic [LEN_W-1:0] load_len = '0;
    logic [REP_W-1:0] load_rep = '0;
    logic             load_valid = 1'b0;
    logic             load_ready;
    logic             data;
    logic             data_valid;
    logic             last;
    logic             busy;
    logic             abort = 1'b0;

    int total = 0;
    int bad = 0;

    sequence_gen #(.WIDTH(WIDTH), .LEN_W(LEN_W), .REP_W(REP_W)) dut (
        .clk(clk), .rst(rst),
        .load_data(load_data), .load_len(load_len), .load_rep(load_rep),
        .load_valid(load_valid), .load_ready(load_ready),
        .data(data), .data_valid(data_valid), .last(last), .busy(busy),
        .abort(abort)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  d;
        logic [2:0]  len;
        logic [3:0]  rep;
        logic [15:0] exp;
        int          n;
        int          flags;
    } vec_t;

    vec_t vt[5];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        logic [3:0] sh;
        int got;
        int cyc;
        int fl;
        sh = 4'b0000;
        got = 0;
        cyc = 0;
        fl = 0;
        load_data  = v.d;
        load_len   = v.len;
        load_rep   = v.rep;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        while (got < v.n && cyc < v.n + 20) begin
            if (data_valid) begin
                chk("vec_bit", data, v.exp[v.n-1-got]);
                chk("vec_last", last, (got == v.n - 1));
                sh = {sh[2:0], data};
                if (sh == 4'b1011) fl++;
                got++;
            end else begin
`ifdef SEQ_GEN_GAP_EN
                chk("vec_gap_data", {data, last}, 0);
`else
                chk("vec_nogap", data_valid, 1);
`endif
            end
            step();
            cyc++;
        end
        chk("vec_count", got, v.n);
        chk("vec_dv_after", data_valid, 0);
        chk("vec_busy_after", busy, 0);
        chk("vec_detector_flags", fl, v.flags);
    endtask

    initial begin
        int dvn;
        int ones;
        int lastn;
        int cyc;

        vt[0] = '{d: 8'b0000_1011, len: 3'd3, rep: 4'd0, exp: 16'b1011, n: 4, flags: 1};
        vt[1] = '{d: 8'b0000_1011, len: 3'd3, rep: 4'd1, exp: 16'b1011_1011, n: 8, flags: 2};
        vt[2] = '{d: 8'hC3, len: 3'd0, rep: 4'd0, exp: 16'h00C3, n: 8, flags: 0};
        vt[3] = '{d: 8'h5A, len: 3'd7, rep: 4'd0, exp: 16'h005A, n: 8, flags: 1};
        vt[4] = '{d: 8'b0000_0010, len: 3'd1, rep: 4'd2, exp: 16'b10_1010, n: 6, flags: 0};

        // reset state while rst is held low
        #12;
        chk("rst_data", data, 0);
        chk("rst_dv", data_valid, 0);
        chk("rst_last", last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", load_ready, 1);
        rst = 1'b1;
        step();

        for (int i = 0; i < 5; i++) begin
            run_vec(vt[i]);
            step();
        end

        // back-to-back chaining with load_valid held
        load_data = 8'b110; load_len = 3'd2; load_rep = 4'd0; load_valid = 1'b1;
        step();
        chk("b2b_c1", {data_valid, data, last, load_ready}, 4'b1100);
        load_data = 8'b01; load_len = 3'd1;
        step();
        chk("b2b_c2", {data_valid, data, last, load_ready}, 4'b1100);
        step();
        chk("b2b_c3", {data_valid, data, last, load_ready}, 4'b1011);
        step();
        chk("b2b_c4", {data_valid, data, last, load_ready}, 4'b1000);
        load_valid = 1'b0;
        step();
        chk("b2b_c5", {data_valid, data, last, load_ready}, 4'b1111);
        step();
        chk("b2b_end", {data_valid, busy}, 2'b00);
        step();

        // abort with a simultaneous load
        load_data = 8'hA5; load_len = 3'd7; load_rep = 4'd0; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        step();
        step();
        chk("abort_bit3", {data_valid, data}, 2'b11);
        abort = 1'b1; load_valid = 1'b1;
        load_data = 8'b1011; load_len = 3'd3; load_rep = 4'd0;
        #1;
        chk("abort_ready", load_ready, 0);
        step();
        chk("abort_cleared", {data_valid, busy, last}, 3'b000);
        chk("abort_idle_ready", load_ready, 1);
        abort = 1'b0;
        step();
        chk("abort_reload_b1", {data_valid, data, busy}, 3'b111);
        load_valid = 1'b0;
        step();
        chk("abort_reload_b2", {data_valid, data}, 2'b10);
        step();
        chk("abort_reload_b3", {data_valid, data}, 2'b11);
        step();
        chk("abort_reload_b4", {data_valid, data, last}, 3'b111);
        step();
        chk("abort_reload_end", busy, 0);

        // asynchronous reset between edges mid-burst
        load_data = 8'hFF; load_len = 3'd7; load_rep = 4'd0; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        step();
        chk("arst_pre", {data_valid, data, busy}, 3'b111);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_outputs", {data_valid, data, last, busy}, 4'b0000);
        chk("arst_ready", load_ready, 1);
        rst = 1'b1;
        load_data = 8'b1011; load_len = 3'd3; load_rep = 4'd0; load_valid = 1'b1;
        step();
        chk("arst_b1", {data_valid, data}, 2'b11);
        load_valid = 1'b0;
        step();
        chk("arst_b2", {data_valid, data}, 2'b10);
        step();
        chk("arst_b3", {data_valid, data}, 2'b11);
        step();
        chk("arst_b4", {data_valid, data, last}, 3'b111);
        step();

        // maximum repeat count
        load_data = 8'b10; load_len = 3'd1; load_rep = 4'd15; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        dvn = 0; ones = 0; lastn = 0; cyc = 0;
        while (busy && cyc < 200) begin
            if (data_valid) dvn++;
            if (data_valid && data) ones++;
            if (last) lastn++;
            step();
            cyc++;
        end
        chk("maxrep_done", busy, 0);
        chk("maxrep_dv_cycles", dvn, 32);
        chk("maxrep_ones", ones, 16);
        chk("maxrep_last_pulses", lastn, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
